sprite_motion_ctrl: RTL



---
 rtl/vga_pkg.sv | 36 +++
 rtl/sprite_motion_ctrl_if.sv | 22 ++
 rtl/sprite_motion_ctrl_btn_debounce.sv | 37 +++
 rtl/sprite_motion_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA geometry, coordinate widths, FSM encoding and axis helpers
package vga_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int XW       = 10;
  localparam int YW       = 9;
  localparam int AW       = 19;

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_SAMPLE = 3'd1;
  localparam logic [2:0] S_MOVE   = 3'd2;
  localparam logic [2:0] S_ADDR   = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } dir_t;

  // Opposite directions cancel; 11-bit math keeps the saturation free of wrap.
  function automatic logic [10:0] step_axis(input logic [10:0] pos, input logic dec,
                                            input logic inc, input logic [10:0] step,
                                            input logic [10:0] lim);
    logic [10:0] r;
    r = pos;
    if (dec && !inc) r = (pos < step) ? 11'd0 : pos - step;
    else if (inc && !dec) r = ((pos + step) > lim) ? lim : pos + step;
    return r;
  endfunction

  function automatic logic [10:0] clamp_to(input logic [10:0] v, input logic [10:0] lim);
    return (v > lim) ? lim : v;
  endfunction
endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// rtl/sprite_motion_ctrl_if.sv - button/vsync/load inputs and committed position outputs
interface sprite_motion_ctrl_if;
  import vga_pkg::*;

  logic          iVS;
  logic          mUp;
  logic          mDown;
  logic          mLeft;
  logic          mRight;
  logic          iLoad;
  logic [XW-1:0] iLoadX;
  logic [YW-1:0] iLoadY;
  logic [XW-1:0] oPosX;
  logic [YW-1:0] oPosY;
  logic [AW-1:0] oTopLeft;
  logic          oMoving;

  modport master (output iVS, mUp, mDown, mLeft, mRight, iLoad, iLoadX, iLoadY,
                  input  oPosX, oPosY, oTopLeft, oMoving);
  modport slave  (input  iVS, mUp, mDown, mLeft, mRight, iLoad, iLoadX, iLoadY,
                  output oPosX, oPosY, oTopLeft, oMoving);
endinterface

// File: rtl/sprite_motion_ctrl_btn_debounce.sv
// rtl/sprite_motion_ctrl_btn_debounce.sv - 2-flop synchronizer plus stable-level counter
// for one active-low button; level_o is active high.
module btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_ni,
  output logic level_o
);
  localparam int             CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q, prev_q, level_q;
  logic [CW-1:0] cnt_q;
  logic          lvl;

  assign lvl     = ~sync2_q;
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= btn_ni;
      sync2_q <= sync1_q;
      prev_q  <= lvl;
      if (lvl != prev_q) cnt_q <= '0;
      else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CW'(1);
      else level_q <= prev_q;
    end
  end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - frame-synchronous sprite position scheduler
// Moves the sprite at most once per FRAME_DIV frames, only during vsync.
module sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int SPRITE_W   = 50,
  parameter int SPRITE_H   = 50,
  parameter int STEP       = 1,
  parameter int FRAME_DIV  = 1,
  parameter int DEB_CYCLES = 50000,
  parameter int INIT_X     = 40,
  parameter int INIT_Y     = 1
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST,
  sprite_motion_ctrl_if.slave  bus
);
  localparam logic [10:0]   MAX_X   = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0]   MAX_Y   = 11'(SCREEN_H - SPRITE_H);
  localparam logic [10:0]   STEP_W  = 11'(STEP);
  localparam logic [7:0]    FD_LAST = 8'(FRAME_DIV - 1);
  localparam logic [XW-1:0] RST_X   = XW'(INIT_X);
  localparam logic [YW-1:0] RST_Y   = YW'(INIT_Y);
  localparam logic [AW-1:0] RST_A   = AW'(INIT_Y * SCREEN_W + INIT_X);

  logic [3:0]    deb;
  logic          vs1_q, vs2_q, vs3_q, vs_start;
  logic [2:0]    state_q, state_d;
  logic [7:0]    frame_cnt_q;
  logic          load_pend_q, load_next_q;
  dir_t          dir_q;
  logic [XW-1:0] nx_q, nx_d, pos_x_q;
  logic [YW-1:0] ny_q, ny_d, pos_y_q;
  logic [AW-1:0] ta, addr_q;
  logic          moving_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up
    (.clk_i(iVGA_CLK), .rst_i(iRST), .btn_ni(bus.mUp), .level_o(deb[3]));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down
    (.clk_i(iVGA_CLK), .rst_i(iRST), .btn_ni(bus.mDown), .level_o(deb[2]));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left
    (.clk_i(iVGA_CLK), .rst_i(iRST), .btn_ni(bus.mLeft), .level_o(deb[1]));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right
    (.clk_i(iVGA_CLK), .rst_i(iRST), .btn_ni(bus.mRight), .level_o(deb[0]));

  assign vs_start     = vs3_q & ~vs2_q;
  assign bus.oPosX    = pos_x_q;
  assign bus.oPosY    = pos_y_q;
  assign bus.oTopLeft = addr_q;
  assign bus.oMoving  = moving_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (vs_start && (frame_cnt_q == FD_LAST || load_pend_q)) state_d = S_SAMPLE;
      S_SAMPLE: state_d = S_MOVE;
      S_MOVE:   state_d = S_ADDR;
      S_ADDR:   state_d = S_COMMIT;
      default:  state_d = S_WAIT;
    endcase
  end

  always_comb begin
    if (load_pend_q) begin
      nx_d = XW'(clamp_to({1'b0, bus.iLoadX}, MAX_X));
      ny_d = YW'(clamp_to({2'b0, bus.iLoadY}, MAX_Y));
    end else begin
      nx_d = XW'(step_axis({1'b0, pos_x_q}, dir_q.left, dir_q.right, STEP_W, MAX_X));
      ny_d = YW'(step_axis({2'b0, pos_y_q}, dir_q.up, dir_q.down, STEP_W, MAX_Y));
    end
  end

  always_comb begin
    if (SCREEN_W == 640) ta = (AW'(ny_q) << 9) + (AW'(ny_q) << 7) + AW'(nx_q);
    else ta = AW'(ny_q) * AW'(SCREEN_W) + AW'(nx_q);
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      vs1_q       <= 1'b1;
      vs2_q       <= 1'b1;
      vs3_q       <= 1'b1;
      state_q     <= S_WAIT;
      frame_cnt_q <= '0;
      load_pend_q <= 1'b0;
      load_next_q <= 1'b0;
      dir_q       <= '0;
      nx_q        <= RST_X;
      ny_q        <= RST_Y;
      pos_x_q     <= RST_X;
      pos_y_q     <= RST_Y;
      addr_q      <= RST_A;
      moving_q    <= 1'b0;
    end else begin
      vs1_q   <= bus.iVS;
      vs2_q   <= vs1_q;
      vs3_q   <= vs2_q;
      state_q <= state_d;
      if (state_q == S_WAIT && vs_start)
        frame_cnt_q <= (state_d == S_SAMPLE) ? 8'd0 : frame_cnt_q + 8'd1;
      // a load arriving after the sequence has started waits for the next frame
      if (state_q == S_COMMIT) begin
        load_pend_q <= load_next_q | bus.iLoad;
        load_next_q <= 1'b0;
      end else if (state_q == S_WAIT) begin
        if (bus.iLoad) load_pend_q <= 1'b1;
      end else if (bus.iLoad) begin
        load_next_q <= 1'b1;
      end
      if (state_q == S_SAMPLE) dir_q <= deb;
      if (state_q == S_MOVE) begin
        nx_q <= nx_d;
        ny_q <= ny_d;
      end
      if (state_q == S_ADDR) begin
        pos_x_q  <= nx_q;
        pos_y_q  <= ny_q;
        addr_q   <= ta;
        moving_q <= (nx_q != pos_x_q) || (ny_q != pos_y_q);
      end
    end
  end
endmodule
